// File: rtl/w0rm_core_wb_pkg.sv
// Shared types and constants for the W0RM core writeback arbiter.
package w0rm_core_wb_pkg;

  // Default configuration of the writeback path.
  localparam int WB_DATA_WIDTH    = 32;
  localparam int WB_NUM_REGISTERS = 16;
  localparam int WB_ADDR_WIDTH    = $clog2(WB_NUM_REGISTERS);
  localparam int WB_FIFO_DEPTH    = 4;

  // Result producers feeding the register file write port.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

  // One buffered register write at the default widths; FIFOs store it flattened as {addr, data}.
  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  // Reset constants.
  localparam wb_src_e WB_RST_LAST_GRANT   = WB_SRC_ALU;
  localparam logic    WB_RST_WRITE_ENABLE = 1'b0;
  localparam logic    WB_RST_READY_EN     = 1'b0;

  // Occupancy counter width: must be able to hold the value DEPTH itself.
  function automatic int wb_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/w0rm_core_wb_fifo.sv
// Per-source synchronous FIFO for buffered register writes.
// Entries are stored as {addr, data}. With WB_HAZARD_CHECK_EN defined, the
// FIFO also exposes per-slot occupancy and destination addresses.
module w0rm_core_wb_fifo
  import w0rm_core_wb_pkg::*;
#(
  parameter int  ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int  DATA_WIDTH = WB_DATA_WIDTH,
  parameter int  DEPTH      = WB_FIFO_DEPTH,
  localparam int WIDTH      = ADDR_WIDTH + DATA_WIDTH,
  localparam int PTR_WIDTH  = $clog2(DEPTH),
  localparam int CNT_WIDTH  = wb_cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head_data,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_WIDTH-1:0] count
`ifdef WB_HAZARD_CHECK_EN
  ,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr
`endif
);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 do_push, do_pop;

  assign full      = (count_q == CNT_WIDTH'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; pushes when full and pops when empty are ignored.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy, cleared by reset (contents are discarded).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; occupancy alone decides validity, so no reset is needed here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef WB_HAZARD_CHECK_EN
  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PTR_WIDTH-1:0] offset;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PTR_WIDTH'(i) - rd_ptr_q;
      entry_valid[i] = ({1'b0, offset} < count_q);
      entry_addr[i]  = mem_q[i][WIDTH-1 -: ADDR_WIDTH];
    end
  end
`endif

endmodule

// File: rtl/w0rm_core_writeback_arbiter.sv
// W0RM core writeback arbiter: buffers ALU and load results in per-source
// FIFOs and round-robins them onto the single register file write port.
// Optional feature macro: WB_HAZARD_CHECK_EN adds pending-write lookup ports.
module w0rm_core_writeback_arbiter
  import w0rm_core_wb_pkg::*;
#(
  parameter int  DATA_WIDTH    = WB_DATA_WIDTH,
  parameter int  NUM_REGISTERS = WB_NUM_REGISTERS,
  parameter int  FIFO_DEPTH    = WB_FIFO_DEPTH,
  localparam int ADDR_WIDTH    = $clog2(NUM_REGISTERS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] port_write_addr,
  output logic [DATA_WIDTH-1:0] port_write_data,
  output logic                  port_write_enable,
  output logic                  idle
`ifdef WB_HAZARD_CHECK_EN
  ,
  input  logic [ADDR_WIDTH-1:0] chk0_addr,
  input  logic [ADDR_WIDTH-1:0] chk1_addr,
  output logic                  chk0_pending,
  output logic                  chk1_pending
`endif
);

  localparam int ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_WIDTH   = wb_cnt_width(FIFO_DEPTH);

  logic                   alu_push, mem_push;
  logic                   alu_pop, mem_pop;
  logic                   alu_full, mem_full;
  logic                   alu_empty, mem_empty;
  logic [CNT_WIDTH-1:0]   alu_count, mem_count;
  logic [ENTRY_WIDTH-1:0] alu_head, mem_head;
  logic [ENTRY_WIDTH-1:0] sel_entry;

  logic                   ready_en_q, ready_en_d;
  wb_src_e                last_grant_q, last_grant_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

`ifdef WB_HAZARD_CHECK_EN
  logic [FIFO_DEPTH-1:0]                 alu_entry_valid, mem_entry_valid;
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] alu_entry_addr, mem_entry_addr;
`endif

  // Readies come from registered state only: a pop in the same cycle never
  // reopens a full FIFO, and both stay low until the cycle after reset.
  assign alu_ready = ready_en_q && !alu_full;
  assign mem_ready = ready_en_q && !mem_full;
  assign alu_push  = alu_valid && alu_ready;
  assign mem_push  = mem_valid && mem_ready;

  assign port_write_addr   = wr_addr_q;
  assign port_write_data   = wr_data_q;
  assign port_write_enable = wr_en_q;
  assign idle              = (alu_count == '0) && (mem_count == '0) && !wr_en_q;

  w0rm_core_wb_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_alu_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (alu_push),
    .push_data   ({alu_addr, alu_data}),
    .pop         (alu_pop),
    .head_data   (alu_head),
    .full        (alu_full),
    .empty       (alu_empty),
    .count       (alu_count)
`ifdef WB_HAZARD_CHECK_EN
    ,
    .entry_valid (alu_entry_valid),
    .entry_addr  (alu_entry_addr)
`endif
  );

  w0rm_core_wb_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_mem_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (mem_push),
    .push_data   ({mem_addr, mem_data}),
    .pop         (mem_pop),
    .head_data   (mem_head),
    .full        (mem_full),
    .empty       (mem_empty),
    .count       (mem_count)
`ifdef WB_HAZARD_CHECK_EN
    ,
    .entry_valid (mem_entry_valid),
    .entry_addr  (mem_entry_addr)
`endif
  );

  // Round-robin grant: a lone non-empty FIFO wins; on contention the source not granted last wins.
  always_comb begin
    alu_pop      = 1'b0;
    mem_pop      = 1'b0;
    last_grant_d = last_grant_q;
    sel_entry    = alu_head;
    if (!alu_empty && !mem_empty) begin
      if (last_grant_q == WB_SRC_ALU) begin
        mem_pop = 1'b1;
      end else begin
        alu_pop = 1'b1;
      end
    end else if (!alu_empty) begin
      alu_pop = 1'b1;
    end else if (!mem_empty) begin
      mem_pop = 1'b1;
    end
    if (alu_pop) begin
      sel_entry    = alu_head;
      last_grant_d = WB_SRC_ALU;
    end else if (mem_pop) begin
      sel_entry    = mem_head;
      last_grant_d = WB_SRC_MEM;
    end
  end

  // Output register next-state: enable pulses for one cycle per pop, addr/data hold otherwise.
  always_comb begin
    ready_en_d = 1'b1;
    wr_en_d    = alu_pop || mem_pop;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (wr_en_d) begin
      wr_addr_d = sel_entry[ENTRY_WIDTH-1 -: ADDR_WIDTH];
      wr_data_d = sel_entry[DATA_WIDTH-1:0];
    end
  end

  // Arbiter and write-port state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready_en_q   <= WB_RST_READY_EN;
      last_grant_q <= WB_RST_LAST_GRANT;
      wr_en_q      <= WB_RST_WRITE_ENABLE;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      ready_en_q   <= ready_en_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

`ifdef WB_HAZARD_CHECK_EN
  // A register is pending while any live FIFO slot or the write on the port targets it.
  always_comb begin
    chk0_pending = 1'b0;
    chk1_pending = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_entry_valid[i] && (alu_entry_addr[i] == chk0_addr)) chk0_pending = 1'b1;
      if (mem_entry_valid[i] && (mem_entry_addr[i] == chk0_addr)) chk0_pending = 1'b1;
      if (alu_entry_valid[i] && (alu_entry_addr[i] == chk1_addr)) chk1_pending = 1'b1;
      if (mem_entry_valid[i] && (mem_entry_addr[i] == chk1_addr)) chk1_pending = 1'b1;
    end
    if (wr_en_q && (wr_addr_q == chk0_addr)) chk0_pending = 1'b1;
    if (wr_en_q && (wr_addr_q == chk1_addr)) chk1_pending = 1'b1;
    if (!reset_n) begin
      chk0_pending = 1'b0;
      chk1_pending = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_w0rm_core_writeback_arbiter.sv
// Scoreboard bench for w0rm_core_writeback_arbiter: a queue-based reference
// model predicts each register write; a negedge monitor compares.
`timescale 1ns/1ps
module tb_w0rm_core_writeback_arbiter;

  localparam int DATA_WIDTH    = 32;
  localparam int NUM_REGISTERS = 16;
  localparam int FIFO_DEPTH    = 4;
  localparam int ADDR_WIDTH    = $clog2(NUM_REGISTERS);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  alu_valid = 1'b0;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_addr = '0;
  logic [DATA_WIDTH-1:0] alu_data = '0;
  logic                  mem_valid = 1'b0;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr = '0;
  logic [DATA_WIDTH-1:0] mem_data = '0;
  logic [ADDR_WIDTH-1:0] port_write_addr;
  logic [DATA_WIDTH-1:0] port_write_data;
  logic                  port_write_enable;
  logic                  idle;
`ifdef WB_HAZARD_CHECK_EN
  logic [ADDR_WIDTH-1:0] chk0_addr = '0;
  logic [ADDR_WIDTH-1:0] chk1_addr = '0;
  logic                  chk0_pending;
  logic                  chk1_pending;
`endif

  always #5 clk = ~clk;

  w0rm_core_writeback_arbiter #(
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_REGISTERS (NUM_REGISTERS),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .alu_valid         (alu_valid),
    .alu_ready         (alu_ready),
    .alu_addr          (alu_addr),
    .alu_data          (alu_data),
    .mem_valid         (mem_valid),
    .mem_ready         (mem_ready),
    .mem_addr          (mem_addr),
    .mem_data          (mem_data),
    .port_write_addr   (port_write_addr),
    .port_write_data   (port_write_data),
    .port_write_enable (port_write_enable),
    .idle              (idle)
`ifdef WB_HAZARD_CHECK_EN
    ,
    .chk0_addr         (chk0_addr),
    .chk1_addr         (chk1_addr),
    .chk0_pending      (chk0_pending),
    .chk1_pending      (chk1_pending)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // Reference state: buffered entries per source, expected port writes, port register.
  ent_t                  aq[$];
  ent_t                  mq[$];
  ent_t                  sb[$];
  bit                    m_rdy_en = 1'b0;
  bit                    m_en     = 1'b0;
  bit                    m_last_mem = 1'b0;
  logic [ADDR_WIDTH-1:0] m_addr = '0;
  logic [DATA_WIDTH-1:0] m_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: at each edge one buffered write moves to the port, then accepted inputs are buffered.
  always @(posedge clk) begin
    bit   a_rdy, b_rdy;
    ent_t e;
    a_rdy = m_rdy_en && (aq.size() < FIFO_DEPTH);
    b_rdy = m_rdy_en && (mq.size() < FIFO_DEPTH);
    if (!reset_n) begin
      aq.delete();
      mq.delete();
      sb.delete();
      m_rdy_en   = 1'b0;
      m_en       = 1'b0;
      m_last_mem = 1'b0;
      m_addr     = '0;
      m_data     = '0;
    end else begin
      m_en = 1'b0;
      e    = '0;
      if (aq.size() > 0 && (mq.size() == 0 || m_last_mem)) begin
        e = aq.pop_front();
        m_last_mem = 1'b0;
        m_en = 1'b1;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_last_mem = 1'b1;
        m_en = 1'b1;
      end
      if (m_en) begin
        m_addr = e.addr;
        m_data = e.data;
        sb.push_back(e);
      end
      if (alu_valid && a_rdy) begin
        e = {alu_addr, alu_data};
        aq.push_back(e);
      end
      if (mem_valid && b_rdy) begin
        e = {mem_addr, mem_data};
        mq.push_back(e);
      end
      m_rdy_en = 1'b1;
    end
  end

  // Monitor: compare port, readies and idle every cycle; pop the scoreboard on each write.
  always @(negedge clk) begin
    ent_t e;
    bit   exp_idle;
    if (armed) begin
      exp_idle = (aq.size() == 0) && (mq.size() == 0) && !m_en;
      check("alu_ready", 64'(alu_ready), 64'(m_rdy_en && (aq.size() < FIFO_DEPTH)));
      check("mem_ready", 64'(mem_ready), 64'(m_rdy_en && (mq.size() < FIFO_DEPTH)));
      check("idle", 64'(idle), 64'(exp_idle));
      check("write_enable", 64'(port_write_enable), 64'(m_en));
      check("addr_hold", 64'(port_write_addr), 64'(m_addr));
      check("data_hold", 64'(port_write_data), 64'(m_data));
      if (port_write_enable === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 64'(port_write_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("sb_addr", 64'(port_write_addr), 64'(e.addr));
          check("sb_data", 64'(port_write_data), 64'(e.data));
        end
      end
`ifdef WB_HAZARD_CHECK_EN
      begin
        bit p0, p1;
        p0 = 1'b0;
        p1 = 1'b0;
        if (reset_n) begin
          foreach (aq[i]) begin
            if (aq[i].addr == chk0_addr) p0 = 1'b1;
            if (aq[i].addr == chk1_addr) p1 = 1'b1;
          end
          foreach (mq[i]) begin
            if (mq[i].addr == chk0_addr) p0 = 1'b1;
            if (mq[i].addr == chk1_addr) p1 = 1'b1;
          end
          if (m_en && m_addr == chk0_addr) p0 = 1'b1;
          if (m_en && m_addr == chk1_addr) p1 = 1'b1;
        end
        check("chk0_pending", 64'(chk0_pending), 64'(p0));
        check("chk1_pending", 64'(chk1_pending), 64'(p1));
      end
`endif
    end
  end

  task automatic drive(input bit av, input logic [ADDR_WIDTH-1:0] aa, input logic [DATA_WIDTH-1:0] ad,
                       input bit mv, input logic [ADDR_WIDTH-1:0] ma, input logic [DATA_WIDTH-1:0] md);
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    mem_valid = mv;
    mem_addr  = ma;
    mem_data  = md;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    armed = 1'b1;
    quiet(2);
    reset_n = 1'b1;
    quiet(2);

`ifdef WB_HAZARD_CHECK_EN
    chk0_addr = ADDR_WIDTH'(5);
    chk1_addr = ADDR_WIDTH'(6);
    drive(1'b1, ADDR_WIDTH'(5), 32'h0000_0055, 1'b0, '0, '0);
    quiet(4);
`endif

    // Single uncontended ALU write.
    drive(1'b1, ADDR_WIDTH'(3), 32'h0000_00A5, 1'b0, '0, '0);
    quiet(4);

    // Both sources every cycle: MEM first, then alternation; FIFOs fill and readies drop.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, ADDR_WIDTH'(1), 32'h1111_0000 + 32'(i), 1'b1, ADDR_WIDTH'(2), 32'h2222_0000 + 32'(i));
    end
    quiet(12);

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_WIDTH'(7 + i), 32'h7777_0000 + 32'(i), 1'b0, '0, '0);
    end
    reset_n = 1'b0;
    quiet(1);
    reset_n = 1'b1;
    quiet(3);

    // Back-to-back ALU-only writes wrap the pointers several times.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, ADDR_WIDTH'(i), 32'hC0DE_0000 + 32'(i), 1'b0, '0, '0);
    end
    quiet(4);

    // Randomised traffic with varying load.
    for (int i = 0; i < 400; i++) begin
`ifdef WB_HAZARD_CHECK_EN
      chk0_addr = ADDR_WIDTH'($urandom_range(0, NUM_REGISTERS - 1));
      chk1_addr = ADDR_WIDTH'($urandom_range(0, NUM_REGISTERS - 1));
`endif
      if (i == 250) begin
        reset_n = 1'b0;
        quiet(1);
        reset_n = 1'b1;
      end
      drive(($urandom_range(0, 99) < ((i < 150) ? 80 : 35)),
            ADDR_WIDTH'($urandom_range(0, NUM_REGISTERS - 1)), DATA_WIDTH'($urandom),
            ($urandom_range(0, 99) < ((i < 150) ? 70 : 30)),
            ADDR_WIDTH'($urandom_range(0, NUM_REGISTERS - 1)), DATA_WIDTH'($urandom));
    end
    quiet(2 * FIFO_DEPTH + 6);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("model_alu_empty", 64'(aq.size()), 64'd0);
    check("model_mem_empty", 64'(mq.size()), 64'd0);
    check("final_idle", 64'(idle), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
